// File: rtl/ysyx_idu_pkg.sv
// Shared encodings for the instruction decode stage: opcodes, control-field
// enumerations and the registered decode bundle.
package ysyx_idu_pkg;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [31:0] InstEbreak = 32'h0010_0073;

  localparam logic [6:0] Funct7Base = 7'h00;
  localparam logic [6:0] Funct7Alt  = 7'h20;
  localparam logic [6:0] Funct7MulD = 7'h01;

  // Low three bits of the base and M-extension codes equal funct3, so the
  // R-type and I-type ALU ops can be formed by concatenation.
  typedef enum logic [4:0] {
    AluAdd    = 5'b00000,
    AluSll    = 5'b00001,
    AluSlt    = 5'b00010,
    AluSltu   = 5'b00011,
    AluXor    = 5'b00100,
    AluSrl    = 5'b00101,
    AluOr     = 5'b00110,
    AluAnd    = 5'b00111,
    AluSub    = 5'b01000,
    AluSra    = 5'b01101,
    AluPassB  = 5'b01110,
    AluMul    = 5'b10000,
    AluMulh   = 5'b10001,
    AluMulhsu = 5'b10010,
    AluMulhu  = 5'b10011,
    AluDiv    = 5'b10100,
    AluDivu   = 5'b10101,
    AluRem    = 5'b10110,
    AluRemu   = 5'b10111
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    BrNone = 3'b000,
    BrEq   = 3'b010,
    BrNe   = 3'b011,
    BrLt   = 3'b100,
    BrGe   = 3'b101,
    BrLtu  = 3'b110,
    BrGeu  = 3'b111
  } br_type_e;

  typedef enum logic [1:0] {
    WrNone = 2'b00,
    WrPc4  = 2'b01,
    WrAlu  = 2'b10,
    WrMem  = 2'b11
  } rf_wr_sel_e;

  typedef enum logic [2:0] {
    DmRdNone = 3'b000,
    DmLb     = 3'b001,
    DmLbu    = 3'b010,
    DmLh     = 3'b011,
    DmLhu    = 3'b100,
    DmLw     = 3'b101
  } dm_rd_sel_e;

  typedef enum logic [1:0] {
    DmWrNone = 2'b00,
    DmSb     = 2'b01,
    DmSh     = 2'b10,
    DmSw     = 2'b11
  } dm_wr_sel_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        rf_wr_en;
    rf_wr_sel_e  rf_wr_sel;
    logic        do_jump;
    br_type_e    br_type;
    logic        alu_a_sel;
    logic        alu_b_sel;
    alu_ctrl_e   alu_ctrl;
    dm_rd_sel_e  dm_rd_sel;
    dm_wr_sel_e  dm_wr_sel;
    logic        illegal;
    logic        ebreak;
  } dec_t;

endpackage

// File: rtl/ysyx_idu_dec.sv
// Purely combinational RV32I (optionally RV32M) instruction decoder.
module ysyx_idu_dec
  import ysyx_idu_pkg::*;
#(
  parameter bit EnM = 1'b0
) (
  input  logic [31:0] inst_i,
  output dec_t        dec_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];

  assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u = {inst_i[31:12], 12'h000};
  assign imm_j = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  // Decode opcode/funct fields into the control bundle; illegal squashes all effects.
  always_comb begin
    dec_o     = '0;
    dec_o.rd  = inst_i[11:7];
    dec_o.rs1 = inst_i[19:15];
    dec_o.rs2 = inst_i[24:20];

    case (opcode)
      OpLui: begin
        dec_o.imm       = imm_u;
        dec_o.rf_wr_sel = WrAlu;
        dec_o.alu_a_sel = 1'b1;
        dec_o.alu_b_sel = 1'b1;
        dec_o.alu_ctrl  = AluPassB;
      end
      OpAuipc: begin
        dec_o.imm       = imm_u;
        dec_o.rf_wr_sel = WrAlu;
        dec_o.alu_b_sel = 1'b1;
      end
      OpJal: begin
        dec_o.imm       = imm_j;
        dec_o.rf_wr_sel = WrPc4;
        dec_o.do_jump   = 1'b1;
        dec_o.alu_b_sel = 1'b1;
      end
      OpJalr: begin
        dec_o.imm       = imm_i;
        dec_o.rf_wr_sel = WrPc4;
        dec_o.do_jump   = 1'b1;
        dec_o.alu_a_sel = 1'b1;
        dec_o.alu_b_sel = 1'b1;
        dec_o.illegal   = (funct3 != 3'b000);
      end
      OpBranch: begin
        // ALU forms the target as pc + imm; the comparison is encoded in br_type.
        dec_o.imm       = imm_b;
        dec_o.alu_b_sel = 1'b1;
        case (funct3)
          3'b000:  dec_o.br_type = BrEq;
          3'b001:  dec_o.br_type = BrNe;
          3'b100:  dec_o.br_type = BrLt;
          3'b101:  dec_o.br_type = BrGe;
          3'b110:  dec_o.br_type = BrLtu;
          3'b111:  dec_o.br_type = BrGeu;
          default: dec_o.illegal = 1'b1;
        endcase
      end
      OpLoad: begin
        dec_o.imm       = imm_i;
        dec_o.rf_wr_sel = WrMem;
        dec_o.alu_a_sel = 1'b1;
        dec_o.alu_b_sel = 1'b1;
        case (funct3)
          3'b000:  dec_o.dm_rd_sel = DmLb;
          3'b100:  dec_o.dm_rd_sel = DmLbu;
          3'b001:  dec_o.dm_rd_sel = DmLh;
          3'b101:  dec_o.dm_rd_sel = DmLhu;
          3'b010:  dec_o.dm_rd_sel = DmLw;
          default: dec_o.illegal   = 1'b1;
        endcase
      end
      OpStore: begin
        dec_o.imm       = imm_s;
        dec_o.alu_a_sel = 1'b1;
        dec_o.alu_b_sel = 1'b1;
        case (funct3)
          3'b000:  dec_o.dm_wr_sel = DmSb;
          3'b001:  dec_o.dm_wr_sel = DmSh;
          3'b010:  dec_o.dm_wr_sel = DmSw;
          default: dec_o.illegal   = 1'b1;
        endcase
      end
      OpImm: begin
        dec_o.imm       = imm_i;
        dec_o.rf_wr_sel = WrAlu;
        dec_o.alu_a_sel = 1'b1;
        dec_o.alu_b_sel = 1'b1;
        dec_o.alu_ctrl  = alu_ctrl_e'({2'b00, funct3});
        if (funct3 == 3'b001) begin
          dec_o.illegal = (funct7 != Funct7Base);
        end else if (funct3 == 3'b101) begin
          if (funct7 == Funct7Alt) begin
            dec_o.alu_ctrl = AluSra;
          end else begin
            dec_o.illegal = (funct7 != Funct7Base);
          end
        end
      end
      OpReg: begin
        dec_o.rf_wr_sel = WrAlu;
        dec_o.alu_a_sel = 1'b1;
        if (funct7 == Funct7Base) begin
          dec_o.alu_ctrl = alu_ctrl_e'({2'b00, funct3});
        end else if (funct7 == Funct7Alt && funct3 == 3'b000) begin
          dec_o.alu_ctrl = AluSub;
        end else if (funct7 == Funct7Alt && funct3 == 3'b101) begin
          dec_o.alu_ctrl = AluSra;
        end else if (EnM && funct7 == Funct7MulD) begin
          dec_o.alu_ctrl = alu_ctrl_e'({2'b10, funct3});
        end else begin
          dec_o.illegal = 1'b1;
        end
      end
      OpSystem: begin
        if (inst_i == InstEbreak) begin
          dec_o.ebreak = 1'b1;
        end else begin
          dec_o.illegal = 1'b1;
        end
      end
      default: dec_o.illegal = 1'b1;
    endcase

    if (dec_o.illegal) begin
      dec_o.imm       = '0;
      dec_o.rf_wr_sel = WrNone;
      dec_o.do_jump   = 1'b0;
      dec_o.br_type   = BrNone;
      dec_o.alu_a_sel = 1'b0;
      dec_o.alu_b_sel = 1'b0;
      dec_o.alu_ctrl  = AluAdd;
      dec_o.dm_rd_sel = DmRdNone;
      dec_o.dm_wr_sel = DmWrNone;
      dec_o.ebreak    = 1'b0;
    end

    // x0 is hardwired, so writes to it are suppressed here rather than downstream.
    dec_o.rf_wr_en = (dec_o.rf_wr_sel != WrNone) && (dec_o.rd != 5'd0);
  end

endmodule

// File: rtl/ysyx_idu_stage.sv
// Decode stage: one valid/ready pipeline register around the decoder.
module ysyx_idu_stage
  import ysyx_idu_pkg::*;
#(
  parameter bit          EN_M = 1'b0,
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [PC_W-1:0] pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [31:0]     imm,
  output logic            rf_wr_en,
  output logic [1:0]      rf_wr_sel,
  output logic            do_jump,
  output logic [2:0]      br_type,
  output logic            alu_a_sel,
  output logic            alu_b_sel,
  output logic [4:0]      alu_ctrl,
  output logic [2:0]      dm_rd_sel,
  output logic [1:0]      dm_wr_sel,
  output logic            illegal,
  output logic            ebreak
);

  dec_t            dec_now;
  dec_t            bundle_q, bundle_d, bundle_vis;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            xfer_in, xfer_out;

  ysyx_idu_dec #(
    .EnM(EN_M)
  ) u_dec (
    .inst_i(inst),
    .dec_o (dec_now)
  );

  assign in_ready = !valid_q || out_ready;
  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = valid_q && out_ready;

  // Next-state: flush wins, then load on accept, else drain on handoff.
  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    pc_d     = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (xfer_in) begin
      valid_d  = 1'b1;
      bundle_d = dec_now;
      pc_d     = pc;
    end else if (xfer_out) begin
      valid_d = 1'b0;
    end
  end

  // Pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
      pc_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
      pc_q     <= pc_d;
    end
  end

  // Outputs read as zero whenever no bundle is held.
  assign bundle_vis = valid_q ? bundle_q : '0;
  assign out_pc     = valid_q ? pc_q : '0;
  assign out_valid  = valid_q;
  assign rd         = bundle_vis.rd;
  assign rs1        = bundle_vis.rs1;
  assign rs2        = bundle_vis.rs2;
  assign imm        = bundle_vis.imm;
  assign rf_wr_en   = bundle_vis.rf_wr_en;
  assign rf_wr_sel  = bundle_vis.rf_wr_sel;
  assign do_jump    = bundle_vis.do_jump;
  assign br_type    = bundle_vis.br_type;
  assign alu_a_sel  = bundle_vis.alu_a_sel;
  assign alu_b_sel  = bundle_vis.alu_b_sel;
  assign alu_ctrl   = bundle_vis.alu_ctrl;
  assign dm_rd_sel  = bundle_vis.dm_rd_sel;
  assign dm_wr_sel  = bundle_vis.dm_wr_sel;
  assign illegal    = bundle_vis.illegal;
  assign ebreak     = bundle_vis.ebreak;

endmodule

// File: tb/tb_ysyx_idu_stage.sv
// Bench for ysyx_idu_stage: two instances (with and without RV32M) share stimulus;
// a queue scoreboard holds accepted instructions and a mnemonic-level model
// supplies the expected bundle.
module tb_ysyx_idu_stage;

  typedef struct packed {
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        wen;
    logic [1:0]  wsel;
    logic        jump;
    logic [2:0]  br;
    logic        asel, bsel;
    logic [4:0]  alu;
    logic [2:0]  dmr;
    logic [1:0]  dmw;
    logic        ill, ebrk;
    logic [31:0] pc;
  } tb_out_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b1, flush = 1'b0;
  logic [31:0] inst = '0, pc = '0;

  int total = 0;
  int bad = 0;
  bit started = 1'b0;
  txn_t sb[$];

  always #5 clk = ~clk;

  logic        m_ir, m_ov, m_wen, m_jump, m_asel, m_bsel, m_ill, m_ebrk;
  logic [31:0] m_pc, m_imm;
  logic [4:0]  m_rd, m_rs1, m_rs2, m_alu;
  logic [1:0]  m_wsel, m_dmw;
  logic [2:0]  m_br, m_dmr;
  logic        i_ir, i_ov, i_wen, i_jump, i_asel, i_bsel, i_ill, i_ebrk;
  logic [31:0] i_pc, i_imm;
  logic [4:0]  i_rd, i_rs1, i_rs2, i_alu;
  logic [1:0]  i_wsel, i_dmw;
  logic [2:0]  i_br, i_dmr;

  ysyx_idu_stage #(.EN_M(1'b1), .PC_W(32)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_ir), .inst(inst), .pc(pc),
    .flush(flush), .out_valid(m_ov), .out_ready(out_ready), .out_pc(m_pc), .rd(m_rd),
    .rs1(m_rs1), .rs2(m_rs2), .imm(m_imm), .rf_wr_en(m_wen), .rf_wr_sel(m_wsel),
    .do_jump(m_jump), .br_type(m_br), .alu_a_sel(m_asel), .alu_b_sel(m_bsel),
    .alu_ctrl(m_alu), .dm_rd_sel(m_dmr), .dm_wr_sel(m_dmw), .illegal(m_ill), .ebreak(m_ebrk)
  );

  ysyx_idu_stage #(.EN_M(1'b0), .PC_W(32)) dut_i (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(i_ir), .inst(inst), .pc(pc),
    .flush(flush), .out_valid(i_ov), .out_ready(out_ready), .out_pc(i_pc), .rd(i_rd),
    .rs1(i_rs1), .rs2(i_rs2), .imm(i_imm), .rf_wr_en(i_wen), .rf_wr_sel(i_wsel),
    .do_jump(i_jump), .br_type(i_br), .alu_a_sel(i_asel), .alu_b_sel(i_bsel),
    .alu_ctrl(i_alu), .dm_rd_sel(i_dmr), .dm_wr_sel(i_dmw), .illegal(i_ill), .ebreak(i_ebrk)
  );

  tb_out_t got_m, got_i;
  assign got_m = {m_rd, m_rs1, m_rs2, m_imm, m_wen, m_wsel, m_jump, m_br, m_asel, m_bsel,
                  m_alu, m_dmr, m_dmw, m_ill, m_ebrk, m_pc};
  assign got_i = {i_rd, i_rs1, i_rs2, i_imm, i_wen, i_wsel, i_jump, i_br, i_asel, i_bsel,
                  i_alu, i_dmr, i_dmw, i_ill, i_ebrk, i_pc};

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h @%0t", name, got, exp, $time);
    end
  endtask

  // Name the instruction the way an assembler listing would.
  function automatic string mnem(input logic [31:0] i, input bit en_m);
    logic [2:0] f3;
    logic [6:0] f7;
    string m;
    f3 = i[14:12];
    f7 = i[31:25];
    m = "ill";
    case (i[6:0])
      7'h37: m = "lui";
      7'h17: m = "auipc";
      7'h6f: m = "jal";
      7'h67: if (f3 == 0) m = "jalr";
      7'h63: case (f3)
               0: m = "beq";  1: m = "bne";  4: m = "blt";
               5: m = "bge";  6: m = "bltu"; 7: m = "bgeu";
               default: m = "ill";
             endcase
      7'h03: case (f3)
               0: m = "lb"; 1: m = "lh"; 2: m = "lw"; 4: m = "lbu"; 5: m = "lhu";
               default: m = "ill";
             endcase
      7'h23: case (f3)
               0: m = "sb"; 1: m = "sh"; 2: m = "sw";
               default: m = "ill";
             endcase
      7'h13: case (f3)
               0: m = "addi"; 2: m = "slti"; 3: m = "sltiu"; 4: m = "xori";
               6: m = "ori";  7: m = "andi";
               1: m = (f7 == 7'h00) ? "slli" : "ill";
               default: m = (f7 == 7'h00) ? "srli" : (f7 == 7'h20) ? "srai" : "ill";
             endcase
      7'h33: begin
        if (f7 == 7'h00) begin
          case (f3)
            0: m = "add"; 1: m = "sll"; 2: m = "slt"; 3: m = "sltu";
            4: m = "xor"; 5: m = "srl"; 6: m = "or";  default: m = "and";
          endcase
        end else if (f7 == 7'h20 && f3 == 0) m = "sub";
        else if (f7 == 7'h20 && f3 == 5) m = "sra";
        else if (f7 == 7'h01 && en_m) begin
          case (f3)
            0: m = "mul"; 1: m = "mulh"; 2: m = "mulhsu"; 3: m = "mulhu";
            4: m = "div"; 5: m = "divu"; 6: m = "rem";    default: m = "remu";
          endcase
        end
      end
      7'h73: if (i == 32'h0010_0073) m = "ebreak";
      default: m = "ill";
    endcase
    return m;
  endfunction

  function automatic logic [4:0] alu_of(input string m);
    case (m)
      "sub": return 5'd8;
      "sll", "slli": return 5'd1;
      "slt", "slti": return 5'd2;
      "sltu", "sltiu": return 5'd3;
      "xor", "xori": return 5'd4;
      "srl", "srli": return 5'd5;
      "sra", "srai": return 5'd13;
      "or", "ori": return 5'd6;
      "and", "andi": return 5'd7;
      "lui": return 5'd14;
      "mul": return 5'd16;    "mulh": return 5'd17;
      "mulhsu": return 5'd18; "mulhu": return 5'd19;
      "div": return 5'd20;    "divu": return 5'd21;
      "rem": return 5'd22;    "remu": return 5'd23;
      default: return 5'd0;
    endcase
  endfunction

  function automatic tb_out_t model(input logic [31:0] i, input logic [31:0] p, input bit en_m);
    tb_out_t e;
    string m;
    m = mnem(i, en_m);
    e = '0;
    e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.pc = p;
    if (m == "ill") begin
      e.ill = 1'b1;
      return e;
    end
    if (m == "ebreak") begin
      e.ebrk = 1'b1;
      return e;
    end
    e.alu = alu_of(m);
    case (i[6:0])
      7'h37: begin e.imm = {i[31:12], 12'h0}; e.wsel = 2; e.asel = 1; e.bsel = 1; end
      7'h17: begin e.imm = {i[31:12], 12'h0}; e.wsel = 2; e.bsel = 1; end
      7'h6f: begin
        e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
        e.wsel = 1; e.jump = 1; e.bsel = 1;
      end
      7'h67: begin
        e.imm = 32'($signed(i[31:20])); e.wsel = 1; e.jump = 1; e.asel = 1; e.bsel = 1;
      end
      7'h63: begin
        e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); e.bsel = 1;
        case (m)
          "beq": e.br = 2; "bne": e.br = 3; "blt": e.br = 4;
          "bge": e.br = 5; "bltu": e.br = 6; default: e.br = 7;
        endcase
      end
      7'h03: begin
        e.imm = 32'($signed(i[31:20])); e.wsel = 3; e.asel = 1; e.bsel = 1;
        case (m)
          "lb": e.dmr = 1; "lbu": e.dmr = 2; "lh": e.dmr = 3; "lhu": e.dmr = 4;
          default: e.dmr = 5;
        endcase
      end
      7'h23: begin
        e.imm = 32'($signed({i[31:25], i[11:7]})); e.asel = 1; e.bsel = 1;
        case (m)
          "sb": e.dmw = 1; "sh": e.dmw = 2; default: e.dmw = 3;
        endcase
      end
      7'h13: begin e.imm = 32'($signed(i[31:20])); e.wsel = 2; e.asel = 1; e.bsel = 1; end
      default: begin e.wsel = 2; e.asel = 1; end
    endcase
    e.wen = (e.wsel != 0) && (e.rd != 0);
    return e;
  endfunction

  // Scoreboard push: model the stage as a queue of at most one accepted instruction.
  always @(posedge clk) begin
    if (rst) begin
      sb.delete();
      started = 1'b1;
    end else if (started) begin
      if (flush) sb.delete();
      else if (in_valid && sb.size() == 0) sb.push_back('{inst: inst, pc: pc});
    end
  end

  // Monitor: compare presented bundle mid-cycle; pop on handshake.
  always @(negedge clk) begin
    if (started) begin
      tb_out_t em, ei;
      bit ev;
      ev = (sb.size() != 0);
      check("out_valid_m", m_ov, ev);
      check("out_valid_i", i_ov, ev);
      check("in_ready_m", m_ir, !ev || out_ready);
      check("in_ready_i", i_ir, !ev || out_ready);
      em = '0;
      ei = '0;
      if (ev) begin
        em = model(sb[0].inst, sb[0].pc, 1'b1);
        ei = model(sb[0].inst, sb[0].pc, 1'b0);
      end
      check("bundle_m", got_m, em);
      check("bundle_i", got_i, ei);
      if (ev && out_ready) void'(sb.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] w, input logic [31:0] p);
    in_valid = 1'b1; inst = w; pc = p;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [10];
    logic [6:0] f7s [4];
    logic [31:0] w;
    ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    f7s = '{7'h00, 7'h20, 7'h01, 7'h00};
    w = $urandom();
    if ($urandom_range(0, 9) == 0) return w;
    w[6:0] = ops[$urandom_range(0, 9)];
    w[31:25] = ($urandom_range(0, 3) == 3) ? w[31:25] : f7s[$urandom_range(0, 2)];
    if ($urandom_range(0, 4) == 0) w[11:7] = 5'd0;
    if (w[6:0] == 7'h73 && w[0]) w = 32'h0010_0073;
    return w;
  endfunction

  initial begin
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", m_ir, 1'b1);

    // addi x1, x0, 5
    tick();
    out_ready = 1'b1;
    issue(32'h0050_0093, 32'h8000_0000);
    check("addi_rd", m_rd, 5'd1);
    check("addi_imm", m_imm, 32'd5);
    check("addi_wsel", m_wsel, 2'b10);
    check("addi_alu", m_alu, 5'b00000);
    check("addi_bsel", m_bsel, 1'b1);

    // Backpressure: A held, B waits three cycles, then follows with no bubble.
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; inst = 32'h0010_0113; pc = 32'h8000_0010;
    tick();
    inst = 32'h0020_0193; pc = 32'h8000_0014;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_in_ready", m_ir, 1'b0);
      check("stall_rd", m_rd, 5'd2);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("nobubble_valid", m_ov, 1'b1);
    check("nobubble_rd", m_rd, 5'd3);

    // mul x0, x1, x2
    tick();
    issue(32'h0220_8033, 32'h8000_0020);
    check("mul_alu", m_alu, 5'b10000);
    check("mul_rs1", m_rs1, 5'd1);
    check("mul_rs2", m_rs2, 5'd2);
    check("mul_wen", m_wen, 1'b0);
    check("mul_illegal_noM", i_ill, 1'b1);

    tick();
    issue(32'h0000_0000, 32'h8000_0024);
    check("zero_illegal", m_ill, 1'b1);
    check("zero_wen", m_wen, 1'b0);
    check("zero_dmw", m_dmw, 2'b00);
    tick();
    issue(32'h0010_0073, 32'h8000_0028);
    check("ebreak", m_ebrk, 1'b1);

    // Flush while holding, with a new instruction offered at the same time.
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; inst = 32'h0030_0213; pc = 32'h8000_0030;
    tick();
    inst = 32'h0040_0293; pc = 32'h8000_0034; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("flush_valid", m_ov, 1'b0);
    tick(); tick();

    // Reset while a bundle is held.
    out_ready = 1'b0;
    in_valid = 1'b1; inst = 32'hfff0_0313; pc = 32'h8000_0040;
    tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", m_ir, 1'b1);
    check("rst_outputs", got_m, '0);

    // Randomised traffic.
    for (int n = 0; n < 1500; n++) begin
      tick();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      inst      = rand_inst();
      pc        = {$urandom()} & 32'hffff_fffc;
    end
    tick();
    in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_idu_stage.md
YSYX_IDU_STAGE -- requirements
Module: ysyx_idu_stage

Interface
REQ-001 Parameter EN_M, default 0, meaning: 1 decodes RV32M (funct7=0x01, op 0x33); 0 treats those encodings as illegal.
REQ-002 Parameter PC_W, default 32, meaning: width of carried PC.
REQ-003 Ports:
- clk  in  1  sole clock, all state on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch word and PC present.
- in_ready  out  1  stage accepts this cycle.
- inst  in  32  instruction word.
- pc  in  PC_W  instruction address.
- flush  in  1  discard held and incoming instruction.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- out_pc  out  PC_W  PC of the held instruction.
- rd, rs1, rs2  out  5 each  register indices.
- imm  out  32  sign-extended I/S/B/U/J immediate.
- rf_wr_en  out  1  writes rd.
- rf_wr_sel  out  2  00 none, 01 pc+4, 10 alu, 11 mem.
- do_jump  out  1  jal or jalr.
- br_type  out  3  000 none, 010 beq, 011 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu.
- alu_a_sel  out  1  1 = rs1, 0 = pc.
- alu_b_sel  out  1  1 = imm, 0 = rs2.
- alu_ctrl  out  5  ALU operation code.
- dm_rd_sel  out  3  000 none, 001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw.
- dm_wr_sel  out  2  00 none, 01 sb, 10 sh, 11 sw.
- illegal  out  1  unsupported encoding.
- ebreak  out  1  held instruction is ebreak.

Function
REQ-004 Full RV32I decode: lui, auipc, jal, jalr, all branches, loads, stores, OP-IMM, OP, ebreak.
REQ-005 alu_ctrl codes:
- 00000 add (also addi, auipc, jal, jalr, loads, stores, branches).
- 01000 sub.
- 00001 sll.
- 00010 slt.
- 00011 sltu.
- 00100 xor.
- 00101 srl.
- 01101 sra.
- 00110 or.
- 00111 and.
- 01110 pass-B (lui).
- With EN_M=1: 1_0fff where fff = funct3 (mul..remu).
REQ-006 Single pipeline register. in_ready = !out_valid | out_ready. Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-007 On transfer in, every decoded field, out_pc and inst-derived indices are registered. Latency: exactly 1 cycle from acceptance to out_valid=1.
REQ-008 Output bundle is held stable while out_valid=1 and out_ready=0.
REQ-009 Simultaneous transfer out and transfer in: new bundle loaded, out_valid stays 1, no bubble.
REQ-010 Transfer out with no transfer in: out_valid clears next cycle.
REQ-011 flush=1: out_valid cleared next cycle, incoming instruction dropped. Flush has priority over any simultaneous transfer in.
REQ-012 illegal=1 for any unmatched opcode/funct combination. All write/enable outputs for an illegal instruction are 0: rf_wr_en, do_jump, br_type, dm_rd_sel, dm_wr_sel.
REQ-013 ebreak is a registered level, valid only while out_valid=1. No DPI call inside this block.
REQ-014 rf_wr_en=0 when rd=0, regardless of opcode.
REQ-015 All outputs qualified by out_valid; no output depends combinationally on inst.

Reset
REQ-016 On rst, next edge: out_valid=0, all decoded outputs 0, out_pc=0, illegal=0, ebreak=0.
REQ-017 rst mid-transfer discards the held bundle. in_ready=1 in the first cycle after rst deasserts.

Structure
REQ-018 Package ysyx_idu_pkg holds the opcode localparams and the alu_ctrl, br_type, rf_wr_sel, dm_rd_sel and dm_wr_sel encodings.
REQ-019 Combinational decode lives in sub-module ysyx_idu_dec; ysyx_idu_stage holds only the handshake register.

Verification
REQ-020 Accept inst 0x00500093 (addi x1,x0,5) with out_ready=1 -> next cycle: out_valid=1, rd=1, imm=5, rf_wr_sel=10, alu_ctrl=00000, alu_b_sel=1.
REQ-021 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, bundle unchanged. Raise out_ready -> next instruction appears the following cycle with no bubble.
REQ-022 EN_M=1, inst 0x02208033 -> alu_ctrl=10000, rs1=1, rs2=2, rf_wr_en=0 (rd=0). EN_M=0 -> illegal=1.
REQ-023 inst 0x00000000 -> illegal=1, rf_wr_en=0, dm_wr_sel=00. inst 0x00100073 -> ebreak=1.
REQ-024 flush asserted together with in_valid=1 while a bundle is held -> out_valid=0 next cycle, incoming instruction never emitted.
REQ-025 rst pulsed while out_valid=1 -> all outputs 0 next cycle, in_ready=1.
